// File: rtl/mdr_ctrl_pkg.sv
// mdr_ctrl_pkg: shared types and the iteration-count helper for the MDR
// sequencing controller.
package mdr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // N-1 for the given op: full-width iterations for MUL/DIV, half for SQRT.
  function automatic int unsigned iter_count(op_e op, int unsigned dw);
    return ((op == OP_SQRT) ? (dw / 2) : dw) - 1;
  endfunction

endpackage

// File: rtl/mdr_iter_cnt.sv
// mdr_iter_cnt: loadable down-counter with zero flag; saturates at zero.
module mdr_iter_cnt #(
  parameter int unsigned CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt  = cnt_q;
  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/mdr_ctrl.sv
// mdr_ctrl: sequencing FSM for the MDR iterative datapath.
// Optional MDR_CTRL_SIGNED_EN adds a one-cycle sign-fix step after RUN.
module mdr_ctrl
  import mdr_ctrl_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = $clog2(DW)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_b_zero,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_sel_src,
  output logic          o_ld_ops,
  output logic          o_clr_acc,
  output logic          o_ld_acc,
  output logic          o_shift_en,
  output logic [1:0]    o_op,
  output logic [CW-1:0] o_iter,
  output logic          o_done,
  output logic          o_error
`ifdef MDR_CTRL_SIGNED_EN
  ,
  input  logic          i_signed,
  input  logic          i_sign_a,
  input  logic          i_sign_b,
  output logic          o_neg_en
`endif
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   err_q, err_d;
  logic   cnt_zero;
`ifdef MDR_CTRL_SIGNED_EN
  logic   neg_q, neg_d;
`endif

  mdr_iter_cnt #(.CW(CW)) u_iter_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (state_q == LOAD),
    .i_load_val (CW'(iter_count(op_q, DW))),
    .i_en       (state_q == RUN),
    .o_cnt      (o_iter),
    .o_zero     (cnt_zero)
  );

  // Next-state, op latch and error/sign flags.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
`ifdef MDR_CTRL_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d    = op_e'(i_op);
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef MDR_CTRL_SIGNED_EN
        neg_d = i_signed && (i_sign_a ^ i_sign_b) &&
                ((op_q == OP_MUL) || (op_q == OP_DIV));
`endif
        if ((op_q == OP_RSVD) || ((op_q == OP_DIV) && i_b_zero)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_zero) begin
`ifdef MDR_CTRL_SIGNED_EN
          state_d = neg_q ? FIX : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MDR_CTRL_SIGNED_EN
      FIX: state_d = DONE;
`endif
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      err_q   <= 1'b0;
`ifdef MDR_CTRL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
`ifdef MDR_CTRL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Moore output decode.
  always_comb begin
    o_ready    = (state_q == IDLE);
    o_busy     = (state_q == LOAD) || (state_q == RUN) || (state_q == FIX);
    o_sel_src  = (state_q == RUN);
    o_ld_ops   = (state_q == LOAD);
    o_clr_acc  = (state_q == LOAD);
    o_ld_acc   = (state_q == RUN) || (state_q == FIX);
    o_shift_en = (state_q == RUN);
    o_done     = (state_q == DONE);
    o_error    = (state_q == DONE) && err_q;
    o_op       = op_q;
`ifdef MDR_CTRL_SIGNED_EN
    o_neg_en   = (state_q == FIX);
`endif
  end

endmodule

// File: tb/tb_mdr_ctrl.sv
// tb_mdr_ctrl: self-checking bench for mdr_ctrl with a cycle-count model,
// directed latency checks and randomized traffic (incl. async resets).
`timescale 1ns/1ps
module tb_mdr_ctrl;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          i_clk, i_rst_n, i_start, i_b_zero;
  logic [1:0]    i_op;
  logic          o_ready, o_busy, o_sel_src, o_ld_ops, o_clr_acc, o_ld_acc;
  logic          o_shift_en, o_done, o_error;
  logic [1:0]    o_op;
  logic [CW-1:0] o_iter;
`ifdef MDR_CTRL_SIGNED_EN
  logic          i_signed, i_sign_a, i_sign_b, o_neg_en;
`endif

  mdr_ctrl #(.DW(DW), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_b_zero(i_b_zero), .o_ready(o_ready), .o_busy(o_busy),
    .o_sel_src(o_sel_src), .o_ld_ops(o_ld_ops), .o_clr_acc(o_clr_acc),
    .o_ld_acc(o_ld_acc), .o_shift_en(o_shift_en), .o_op(o_op),
    .o_iter(o_iter), .o_done(o_done), .o_error(o_error)
`ifdef MDR_CTRL_SIGNED_EN
    , .i_signed(i_signed), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
    .o_neg_en(o_neg_en)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mk = cycles since the accepting edge (0 = idle).
  // Cycle 1 is the load cycle, RUN occupies cycles 2..N+1, an optional fix
  // cycle follows, and the completion cycle is mend.
  int   mk, mn, mend, miter;
  int   mop;
  bit   merr, mfix;

  function automatic bit model_fix();
`ifdef MDR_CTRL_SIGNED_EN
    return i_signed && (i_sign_a != i_sign_b) && (mop < 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_err();
    return (mop == 3) || (mop == 1 && i_b_zero);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mk <= 0; mop <= 0; miter <= 0; merr <= 1'b0; mfix <= 1'b0;
      mend <= 0; mn <= DW;
    end else if (mk == 0) begin
      if (i_start) begin
        mk  <= 1;
        mop <= int'(i_op);
        mn  <= (i_op == 2'b10) ? DW / 2 : DW;
      end
    end else if (mk == 1) begin
      merr  <= model_err();
      mfix  <= model_fix() && !model_err();
      mend  <= model_err() ? 2 : mn + 2 + ((model_fix() && !model_err()) ? 1 : 0);
      miter <= mn - 1;
      mk    <= 2;
    end else if (mk == mend) begin
      mk   <= 0;
      merr <= 1'b0;
    end else begin
      if (mk <= mn + 1 && miter > 0) miter <= miter - 1;
      mk <= mk + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    int run, fx, dn, bs;
    dn  = (mk >= 2 && mk == mend) ? 1 : 0;
    run = (mk >= 2 && !merr && mk <= mn + 1) ? 1 : 0;
    fx  = (mfix && mk == mn + 2) ? 1 : 0;
    bs  = (mk >= 1 && dn == 0) ? 1 : 0;
    chk("ready",  o_ready,    mk == 0);
    chk("busy",   o_busy,     bs);
    chk("sel",    o_sel_src,  run);
    chk("ld_ops", o_ld_ops,   mk == 1);
    chk("clr",    o_clr_acc,  mk == 1);
    chk("ld_acc", o_ld_acc,   run | fx);
    chk("shift",  o_shift_en, run);
    chk("op",     o_op,       mop);
    chk("iter",   o_iter,     miter);
    chk("done",   o_done,     dn);
    chk("error",  o_error,    dn & merr);
`ifdef MDR_CTRL_SIGNED_EN
    chk("neg_en", o_neg_en,   fx);
`endif
  end

  task automatic wait_idle();
    int ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (o_ready) begin ok = 1; break; end
    end
    chk("wait_idle", ok, 1);
  endtask

  // Issue one op from idle and measure cycles from the accepting edge.
  task automatic run_op(input logic [1:0] op, input logic bz, input logic hold,
                        output int done_cyc, output int shifts, output int lds,
                        output int err_at_done);
    i_op = op; i_b_zero = bz; i_start = 1'b1;
    @(posedge i_clk); #1;
    if (hold) i_op = 2'b01; else i_start = 1'b0;
    done_cyc = 0; shifts = 0; lds = 0; err_at_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      shifts += int'(o_shift_en);
      lds    += int'(o_ld_ops);
      if (o_done) begin done_cyc = c; err_at_done = int'(o_error); break; end
    end
    i_start = 1'b0; i_b_zero = 1'b0;
  endtask

  initial begin
    int dc, sh, ld, er, seen_done, hit;
    i_rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_b_zero = 1'b0;
`ifdef MDR_CTRL_SIGNED_EN
    i_signed = 1'b0; i_sign_a = 1'b0; i_sign_b = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_err",   o_error, 0);
    chk("rst_iter",  o_iter, 0);

    // MUL: 1 load cycle, 16 shifts, done on cycle 18.
    run_op(2'b00, 1'b0, 1'b0, dc, sh, ld, er);
    chk("mul_done_cyc", dc, 18); chk("mul_shifts", sh, 16);
    chk("mul_lds", ld, 1);       chk("mul_err", er, 0);
    @(negedge i_clk); chk("mul_ready_after", o_ready, 1);

    // SQRT with i_start held through RUN.
    wait_idle();
    run_op(2'b10, 1'b0, 1'b1, dc, sh, ld, er);
    chk("sqrt_done_cyc", dc, 10); chk("sqrt_shifts", sh, 8);

    // Error paths.
    wait_idle();
    run_op(2'b01, 1'b1, 1'b0, dc, sh, ld, er);
    chk("divz_done_cyc", dc, 2); chk("divz_shifts", sh, 0); chk("divz_err", er, 1);
    wait_idle();
    run_op(2'b11, 1'b0, 1'b0, dc, sh, ld, er);
    chk("rsvd_done_cyc", dc, 2); chk("rsvd_shifts", sh, 0); chk("rsvd_err", er, 1);
    wait_idle();
    run_op(2'b01, 1'b0, 1'b0, dc, sh, ld, er);
    chk("div_done_cyc", dc, 18); chk("div_err", er, 0);

    // Async reset while o_iter==7 in RUN.
    wait_idle();
    #1 i_op = 2'b00; i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_shift_en && o_iter == 4'd7) begin hit = 1; break; end
    end
    chk("rst_mid_reached", hit, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", o_busy, 0);   chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_iter", o_iter, 0);   chk("rst_mid_shift", o_shift_en, 0);
    repeat (2) @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    seen_done = 0;
    repeat (25) begin @(negedge i_clk); seen_done += int'(o_done); end
    chk("rst_mid_no_done", seen_done, 0);

`ifdef MDR_CTRL_SIGNED_EN
    i_signed = 1'b1; i_sign_a = 1'b1; i_sign_b = 1'b0;
    wait_idle();
    run_op(2'b00, 1'b0, 1'b0, dc, sh, ld, er);
    chk("sgn_fix_done_cyc", dc, 19);
    i_sign_b = 1'b1;
    wait_idle();
    run_op(2'b00, 1'b0, 1'b0, dc, sh, ld, er);
    chk("sgn_nofix_done_cyc", dc, 18);
    i_signed = 1'b0; i_sign_a = 1'b0; i_sign_b = 1'b0;
`endif

    // Randomized traffic with occasional mid-cycle async reset pulses.
    for (int c = 0; c < 1500; c++) begin
      @(negedge i_clk); #1;
      i_start  = ($urandom_range(0, 3) == 0);
      i_op     = 2'($urandom_range(0, 3));
      i_b_zero = ($urandom_range(0, 3) == 0);
`ifdef MDR_CTRL_SIGNED_EN
      i_signed = 1'($urandom_range(0, 1));
      i_sign_a = 1'($urandom_range(0, 1));
      i_sign_b = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 249) == 0) begin
        i_rst_n = 1'b0;
        #2 i_rst_n = 1'b1;
      end
    end
    i_start = 1'b0;
    wait_idle();
    @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_ctrl.md
Name: mdr_ctrl

Overview:
Sequencing controller for the MDR (multiply/divide/root) iterative datapath. It accepts an operation request, then drives the operand-select muxes, register load enables, shift enable and iteration count. It handles the start/done handshake and flags illegal requests. It sits between the MDR top-level request interface and the datapath registers and 2:1 operand muxes.

Parameters:
DW, 16, datapath operand width in bits; even, >= 4.
CW, $clog2(DW), iteration counter width.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  request strobe; accepted only while o_ready=1.
i_op  in  2  operation: 00 MUL, 01 DIV, 10 SQRT, 11 reserved.
i_b_zero  in  1  datapath flag: divisor register equals zero; sampled in LOAD.
o_ready  out  1  controller idle, can accept i_start.
o_busy  out  1  operation in progress (LOAD, RUN, FIX).
o_sel_src  out  1  operand mux select: 0 = external operands, 1 = datapath feedback.
o_ld_ops  out  1  load operand registers A and B.
o_clr_acc  out  1  clear accumulator/remainder register.
o_ld_acc  out  1  load accumulator/remainder register.
o_shift_en  out  1  shift datapath one iteration.
o_op  out  2  latched operation code, held stable from LOAD through DONE.
o_iter  out  CW  remaining-iteration count: counts down during RUN.
o_done  out  1  one-cycle completion pulse.
o_error  out  1  valid with o_done: reserved op or divide-by-zero.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, counter 0, o_op 00, o_ready=1, all other outputs 0. Reset mid-operation aborts immediately, with no o_done.
- Outputs are a Moore decode of the registered state, plus the registered counter and op.
- IDLE: o_ready=1. When i_start=1: latch i_op and go to LOAD. i_start while not IDLE is ignored.
- LOAD (1 cycle): o_ld_ops=1, o_clr_acc=1, o_sel_src=0, o_busy=1.
  - Counter loads N-1, where N = DW for MUL/DIV and N = DW/2 for SQRT.
  - If op=11, or op=DIV with i_b_zero=1: set error flag and go to DONE, skipping RUN.
  - Otherwise go to RUN.
- RUN (N cycles): o_shift_en=1, o_ld_acc=1, o_sel_src=1, o_busy=1.
  - Counter decrements each cycle. When counter==0, go to FIX if the feature is enabled and correction is required; otherwise go to DONE. The counter never wraps.
- DONE (1 cycle): o_done=1, o_error=error flag, o_ready=0. Next state IDLE; the error flag clears on leaving DONE.
- Latency from the i_start accept edge to o_done: N+2 cycles (MUL/DIV DW=16: 18 cycles; SQRT: 10 cycles). Error path: 2 cycles.
- Back-to-back: i_start asserted in the cycle after DONE is accepted. Throughput is one operation per N+3 cycles.
- o_error is 0 whenever o_done=0.

Optional Feature:
Macro MDR_CTRL_SIGNED_EN.
- Defined:
  - Adds input i_signed (1) and inputs i_sign_a, i_sign_b (1 each), sampled in LOAD.
  - Adds output o_neg_en (1).
  - For MUL/DIV with i_signed=1 and i_sign_a^i_sign_b=1, RUN exits to FIX.
  - FIX (1 cycle): o_neg_en=1, o_ld_acc=1, o_busy=1, then DONE. Latency becomes N+3 cycles.
  - SQRT never enters FIX.
- Undefined: the ports above and the FIX state do not exist, and RUN always exits to DONE.

Decomposition:
- Package mdr_ctrl_pkg holds:
  - state enum: IDLE, LOAD, RUN, FIX, DONE;
  - op enum: OP_MUL, OP_DIV, OP_SQRT, OP_RSVD;
  - function iter_count(op, DW) returning N-1.
- Sub-module mdr_iter_cnt: loadable down-counter with load value, enable and zero flag, CW wide.
- The FSM stays in mdr_ctrl.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 3 cycles, release → o_ready=1; o_busy, o_done and o_error are 0; o_iter=0.
- MUL, DW=16: pulse i_start with i_op=00 → o_ld_ops high for exactly 1 cycle, then o_shift_en high for 16 cycles with o_iter 15 down to 0, then o_done=1 and o_error=0 on cycle 18; o_ready returns the next cycle.
- SQRT: i_op=10 → 8 RUN cycles, o_done on cycle 10. Also: i_start held high during RUN → no restart, o_op stays 10.
- Error paths: DIV with i_b_zero=1 in LOAD → o_done and o_error on cycle 2, with no o_shift_en ever. i_op=11 → same result.
- Async reset mid-RUN: drop i_rst_n when o_iter=7 → outputs go to reset values immediately, and no o_done follows.
- With MDR_CTRL_SIGNED_EN: MUL with i_signed=1, i_sign_a=1, i_sign_b=0 → o_neg_en for 1 cycle after RUN, then o_done on cycle 19. With i_sign_a=i_sign_b=1 → no FIX, o_done on cycle 18.
